// File: rtl/fpu_bus_if.sv
// fpu_bus_if: byte-wide CPU bus front end for the FPU core.
//
// The host writes operand A, operand B and a 4-bit opcode through a 16-entry
// register window. A write to the command register launches the core with a
// level start/done handshake. The 32-bit result is latched on completion and
// can be read back byte by byte, alongside a status register.
//
// Ports:
//   clk, arst          clock, synchronous active-high reset
//   cs, wr, rd         chip select, write strobe, read strobe
//   addr[3:0]          register index
//   data_in[7:0]       write data
//   data_out[7:0]      registered read data (1-cycle latency, holds otherwise)
//   fpu_op/fpu_a/fpu_b opcode and operands to the core (register copies)
//   fpu_start          start request, held until fpu_done is seen
//   fpu_done           core result valid, held until fpu_start falls
//   fpu_result[31:0]   core result
//   irq                completion interrupt
//
// Register map: 0x0-0x3 A, 0x4-0x7 B, 0x8 opcode, 0x9 command,
//               0xA status {err,done,busy}, 0xB-0xE result, 0xF irq control.
//
// Optional feature macro: FPU_IRQ_EN. When undefined, irq is tied low and
// register 0xF ignores writes and reads as 0.

module fpu_bus_if (
  input  logic        clk,
  input  logic        arst,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [3:0]  addr,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic [3:0]  fpu_op,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic        fpu_start,
  input  logic        fpu_done,
  input  logic [31:0] fpu_result,
  output logic        irq
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [3:0] OP_ILLEGAL = 4'hF;

  logic [1:0]  r_state;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [3:0]  r_op;
  logic [31:0] r_result;
  logic        r_start;
  logic        r_done;
  logic        r_err;
  logic [7:0]  r_dout;

  logic        w_wr;
  logic        w_rd;
  logic        w_busy;
  logic        w_cmd;
  logic        w_complete;
  logic [7:0]  w_status;
  logic [7:0]  w_irq_ctl;
  logic [7:0]  w_rdata;

  assign w_wr       = cs & wr;
  assign w_rd       = cs & rd;
  assign w_busy     = (r_state != S_IDLE);
  // A command is only accepted from IDLE; during a transaction it is dropped.
  assign w_cmd      = w_wr && (addr == 4'h9) && (r_state == S_IDLE);
  assign w_complete = (r_state == S_REQ) && fpu_done;
  assign w_status   = {5'b0, r_err, r_done, w_busy};

  always_ff @(posedge clk) begin
    if (arst) begin
      r_state  <= S_IDLE;
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= '0;
      r_result <= '0;
      r_start  <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
      r_dout   <= '0;
    end else begin
      // Operand/opcode writes are locked out while a transaction is running
      // so the core sees stable inputs for its whole operation.
      if (w_wr && !w_busy) begin
        if (addr[3:2] == 2'b00) r_a[{addr[1:0], 3'b000} +: 8] <= data_in;
        if (addr[3:2] == 2'b01) r_b[{addr[1:0], 3'b000} +: 8] <= data_in;
        if (addr == 4'h8)       r_op <= data_in[3:0];
      end

      case (r_state)
        S_IDLE: begin
          if (w_cmd) begin
            r_done <= 1'b0;
            if (r_op == OP_ILLEGAL) begin
              r_err <= 1'b1;
            end else begin
              r_err   <= 1'b0;
              r_start <= 1'b1;
              r_state <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (fpu_done) begin
            r_result <= fpu_result;
            r_start  <= 1'b0;
            r_done   <= 1'b1;
            r_state  <= S_RELEASE;
          end
        end
        S_RELEASE: begin
          // Wait for the core to drop done before accepting a new command.
          if (!fpu_done) r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_start <= 1'b0;
        end
      endcase

      // Read data reflects register state before this edge's updates.
      if (w_rd) r_dout <= w_rdata;
    end
  end

`ifdef FPU_IRQ_EN
  logic r_irq_en;
  logic r_irq;
  logic w_irq_clr;

  assign w_irq_clr = (w_wr && (addr == 4'hF) && data_in[1]) || w_cmd;

  always_ff @(posedge clk) begin
    if (arst) begin
      r_irq_en <= 1'b0;
      r_irq    <= 1'b0;
    end else begin
      if (w_wr && (addr == 4'hF)) r_irq_en <= data_in[0];
      // Clear takes priority over a completion on the same edge.
      if (w_irq_clr)                  r_irq <= 1'b0;
      else if (w_complete && r_irq_en) r_irq <= 1'b1;
    end
  end

  assign irq       = r_irq;
  assign w_irq_ctl = {7'b0, r_irq_en};
`else
  logic w_unused;
  assign w_unused  = w_complete;
  assign irq       = 1'b0;
  assign w_irq_ctl = 8'h00;
`endif

  always_comb begin
    w_rdata = 8'h00;
    case (addr)
      4'h0, 4'h1, 4'h2, 4'h3: w_rdata = r_a[{addr[1:0], 3'b000} +: 8];
      4'h4, 4'h5, 4'h6, 4'h7: w_rdata = r_b[{addr[1:0], 3'b000} +: 8];
      4'h8:                   w_rdata = {4'b0, r_op};
      4'hA:                   w_rdata = w_status;
      4'hB:                   w_rdata = r_result[7:0];
      4'hC:                   w_rdata = r_result[15:8];
      4'hD:                   w_rdata = r_result[23:16];
      4'hE:                   w_rdata = r_result[31:24];
      4'hF:                   w_rdata = w_irq_ctl;
      default:                w_rdata = 8'h00;
    endcase
  end

  assign data_out  = r_dout;
  assign fpu_op    = r_op;
  assign fpu_a     = r_a;
  assign fpu_b     = r_b;
  assign fpu_start = r_start;

endmodule

// File: tb/tb_fpu_bus_if.sv
module tb_fpu_bus_if;

  logic        clk;
  logic        arst;
  logic        cs;
  logic        wr;
  logic        rd;
  logic [3:0]  addr;
  logic [7:0]  data_in;
  logic [7:0]  data_out;
  logic [3:0]  fpu_op;
  logic [31:0] fpu_a;
  logic [31:0] fpu_b;
  logic        fpu_start;
  logic        fpu_done;
  logic [31:0] fpu_result;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int n_starts = 0;
  int core_cnt = 0;
  bit irq_seen = 0;

  fpu_bus_if dut (
    .clk(clk), .arst(arst), .cs(cs), .wr(wr), .rd(rd), .addr(addr),
    .data_in(data_in), .data_out(data_out), .fpu_op(fpu_op), .fpu_a(fpu_a),
    .fpu_b(fpu_b), .fpu_start(fpu_start), .fpu_done(fpu_done),
    .fpu_result(fpu_result), .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Core model: 5-cycle latency, done held until start falls.
  function automatic logic [31:0] core_calc(logic [3:0] op, logic [31:0] a, logic [31:0] b);
    if (a == 32'h3F800000 && b == 32'h40000000) begin
      if (op == 4'h0) return 32'h40400000;  // 1.0 + 2.0
      if (op == 4'h2) return 32'h40000000;  // 1.0 * 2.0
    end
    return a ^ b;
  endfunction

  always @(negedge clk) begin
    if (arst) begin
      fpu_done = 1'b0;
      core_cnt = 0;
    end else if (!fpu_start) begin
      fpu_done = 1'b0;
      core_cnt = 0;
    end else if (!fpu_done) begin
      core_cnt = core_cnt + 1;
      if (core_cnt >= 5) begin
        fpu_result = core_calc(fpu_op, fpu_a, fpu_b);
        fpu_done   = 1'b1;
      end
    end
  end

  always @(posedge fpu_start) n_starts = n_starts + 1;
  always @(posedge clk) if (irq === 1'b1) irq_seen = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic bus_write(input logic [3:0] a, input logic [7:0] d);
    cs = 1'b1; wr = 1'b1; addr = a; data_in = d;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [7:0] d);
    cs = 1'b1; rd = 1'b1; addr = a;
    @(posedge clk); #1;
    d = data_out;
    cs = 1'b0; rd = 1'b0;
  endtask

  task automatic wait_status(input logic [7:0] exp, input string name);
    logic [7:0] s;
    s = 8'hxx;
    for (int i = 0; i < 40; i++) begin
      bus_read(4'hA, s);
      if (s == exp) break;
    end
    check(name, {24'b0, s}, {24'b0, exp});
  endtask

  task automatic write_operands(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    for (int i = 0; i < 4; i++) bus_write(4'(i), a[i*8 +: 8]);
    for (int i = 0; i < 4; i++) bus_write(4'(4 + i), b[i*8 +: 8]);
    bus_write(4'h8, {4'b0, op});
  endtask

  typedef struct {
    logic [3:0] a;
    logic       do_wr;
    logic [7:0] wd;
    logic [7:0] exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    logic [7:0] r;
    cs = 0; wr = 0; rd = 0; addr = 0; data_in = 0;
    fpu_done = 0; fpu_result = 0;
    vecs[0]  = '{4'h0, 1'b1, 8'h11, 8'h11};
    vecs[1]  = '{4'h1, 1'b1, 8'h22, 8'h22};
    vecs[2]  = '{4'h2, 1'b1, 8'h33, 8'h33};
    vecs[3]  = '{4'h3, 1'b1, 8'h44, 8'h44};
    vecs[4]  = '{4'h4, 1'b1, 8'h55, 8'h55};
    vecs[5]  = '{4'h5, 1'b1, 8'h66, 8'h66};
    vecs[6]  = '{4'h6, 1'b1, 8'h77, 8'h77};
    vecs[7]  = '{4'h7, 1'b1, 8'h88, 8'h88};
    vecs[8]  = '{4'h8, 1'b1, 8'hA5, 8'h05};
    vecs[9]  = '{4'h9, 1'b0, 8'h00, 8'h00};
    vecs[10] = '{4'hA, 1'b0, 8'h00, 8'h00};
    vecs[11] = '{4'hB, 1'b1, 8'h55, 8'h00};

    // Reset
    arst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_data_out", {24'b0, data_out}, 32'h0);
    check("rst_fpu_start", {31'b0, fpu_start}, 32'h0);
    check("rst_fpu_a", fpu_a, 32'h0);
    check("rst_fpu_b", fpu_b, 32'h0);
    check("rst_fpu_op", {28'b0, fpu_op}, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    arst = 1'b0;
    bus_read(4'hA, r);
    check("rst_status", {24'b0, r}, 32'h0);

    // Register window write/readback table
    for (int i = 0; i < 12; i++) begin
      if (vecs[i].do_wr) bus_write(vecs[i].a, vecs[i].wd);
      bus_read(vecs[i].a, r);
      check($sformatf("reg_rb_%0h", vecs[i].a), {24'b0, r}, {24'b0, vecs[i].exp});
    end
    check("tbl_fpu_a", fpu_a, 32'h44332211);
    check("tbl_fpu_b", fpu_b, 32'h88776655);
    check("tbl_fpu_op", {28'b0, fpu_op}, 32'h5);

    // Simultaneous write and read: old value returned, write performed
    cs = 1'b1; wr = 1'b1; rd = 1'b1; addr = 4'h0; data_in = 8'h99;
    @(posedge clk); #1;
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
    check("wr_rd_old", {24'b0, data_out}, 32'h11);
    bus_read(4'h0, r);
    check("wr_rd_new", {24'b0, r}, 32'h99);

    // Add transaction with busy lockout
    write_operands(32'h3F800000, 32'h40000000, 4'h0);
    bus_write(4'h9, 8'h01);
    check("add_start", {31'b0, fpu_start}, 32'h1);
    bus_write(4'h0, 8'hFF);
    check("lockout_a", fpu_a, 32'h3F800000);
    bus_read(4'hA, r);
    check("busy_status", {24'b0, r}, 32'h01);
    bus_write(4'h9, 8'h01);
    wait_status(8'h02, "add_status");
    check("add_one_start", n_starts, 1);
    check("add_start_low", {31'b0, fpu_start}, 32'h0);
    bus_read(4'hB, r); check("add_res0", {24'b0, r}, 32'h00);
    bus_read(4'hC, r); check("add_res1", {24'b0, r}, 32'h00);
    bus_read(4'hD, r); check("add_res2", {24'b0, r}, 32'h40);
    bus_read(4'hE, r); check("add_res3", {24'b0, r}, 32'h40);

    // Illegal opcode, then recovery
    bus_write(4'h8, 8'h0F);
    bus_write(4'h9, 8'h01);
    repeat (2) @(posedge clk);
    #1;
    check("ill_no_start", {31'b0, fpu_start}, 32'h0);
    bus_read(4'hA, r);
    check("ill_status", {24'b0, r}, 32'h04);
    check("ill_starts", n_starts, 1);
    bus_write(4'h8, 8'h02);
    bus_write(4'h9, 8'h01);
    check("mul_start", {31'b0, fpu_start}, 32'h1);
    bus_read(4'hA, r);
    check("mul_err_clr", {24'b0, r}, 32'h01);
    wait_status(8'h02, "mul_status");
    bus_read(4'hE, r); check("mul_res3", {24'b0, r}, 32'h40);
    bus_read(4'hB, r); check("mul_res0", {24'b0, r}, 32'h00);

`ifdef FPU_IRQ_EN
    // Interrupt on completion, then software clear
    bus_write(4'hF, 8'h01);
    bus_read(4'hF, r);
    check("irq_en_rb", {24'b0, r}, 32'h01);
    bus_write(4'h9, 8'h01);
    for (int i = 0; i < 40 && fpu_done !== 1'b1; i++) @(negedge clk);
    check("irq_pre", {31'b0, irq}, 32'h0);
    @(posedge clk); #1;
    check("irq_set", {31'b0, irq}, 32'h1);
    check("irq_start_low", {31'b0, fpu_start}, 32'h0);
    bus_write(4'hF, 8'h02);
    check("irq_clr", {31'b0, irq}, 32'h0);
    wait_status(8'h02, "irq_status");
`else
    // Without the interrupt option irq never rises and 0xF reads 0
    bus_write(4'hF, 8'h01);
    bus_read(4'hF, r);
    check("irq_ctl_rd0", {24'b0, r}, 32'h00);
    bus_write(4'h9, 8'h01);
    wait_status(8'h02, "noirq_status");
    check("irq_never", {31'b0, irq_seen}, 32'h0);
`endif

    // Reset in the middle of a request
    bus_write(4'h9, 8'h01);
    check("mid_start", {31'b0, fpu_start}, 32'h1);
    arst = 1'b1;
    @(posedge clk); #1;
    arst = 1'b0;
    check("mid_start_low", {31'b0, fpu_start}, 32'h0);
    check("mid_fpu_a", fpu_a, 32'h0);
    bus_read(4'hA, r);
    check("mid_status", {24'b0, r}, 32'h00);
    bus_read(4'hE, r);
    check("mid_result", {24'b0, r}, 32'h00);
    repeat (8) @(posedge clk);
    #1;
    check("mid_no_restart", {31'b0, fpu_start}, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fpu_bus_if.md
# fpu_bus_if

Byte-wide host interface that sits directly upstream of the FPU core and feeds it. The 8-bit CPU bus writes operands and an opcode through a 16-entry register window. A command write launches the core with a level start/done handshake matching the core's idle → wait → finish → wait-start-low sequence. The 32-bit result is latched and exposed for byte-wise readback, alongside a status register.

## Interface
- No parameters.
- `clk`  in  1  system clock
- `arst`  in  1  reset, synchronous, active-high
- `cs`  in  1  chip select
- `wr`  in  1  write strobe, qualified by `cs`
- `rd`  in  1  read strobe, qualified by `cs`
- `addr`  in  4  register index
- `data_in`  in  8  write data
- `data_out`  out  8  registered read data
- `fpu_op`  out  4  opcode to core (e_fpu_op encoding)
- `fpu_a`  out  32  operand A
- `fpu_b`  out  32  operand B
- `fpu_start`  out  1  start request to core
- `fpu_done`  in  1  core result valid, held until `fpu_start` falls
- `fpu_result`  in  32  core result, valid while `fpu_done`=1
- `irq`  out  1  completion interrupt (see Configuration)
- All outputs reset to 0.

## Operation
- Register map (byte 0 = LSB):
  - 0x0–0x3: A bytes 0..3 (R/W)
  - 0x4–0x7: B bytes 0..3 (R/W)
  - 0x8: opcode, bits[3:0] R/W, bits[7:4] read 0
  - 0x9: command; any write = start; reads 0
  - 0xA: status, bit0 busy, bit1 done, bit2 err, rest 0
  - 0xB–0xE: result bytes 0..3 (RO)
  - 0xF: irq control; bit0 = irq enable; write bit1=1 clears irq
- FSM states: IDLE, REQ, RELEASE.
  - IDLE: command write with opcode ≠ 4'hF → REQ, `fpu_start`←1, done←0, err←0.
  - IDLE: command write with opcode = 4'hF → stay IDLE, err←1, done←0, no start.
  - REQ: `fpu_done`=1 → latch `fpu_result`, `fpu_start`←0, done←1, → RELEASE.
  - RELEASE: `fpu_done`=0 → IDLE.
- busy = (state ≠ IDLE).
- While busy, writes to 0x0–0x9 are ignored. Operands and opcode stay stable for the whole transaction.
- `fpu_a`/`fpu_b`/`fpu_op` are continuous copies of the operand and opcode registers.
- Result register holds its value until the next completion. Reset clears it to 0.
- Writes to read-only addresses are ignored. Reads of undefined bits return 0.

## Timing
- Register write takes effect at the rising edge where `cs&wr`.
- Read: `data_out` updates at the edge where `cs&rd`, reflecting pre-edge register state. Latency is 1 cycle; otherwise `data_out` holds.
- Simultaneous `wr` and `rd`: the write is performed; `data_out` returns the old value.
- Command write at edge N → `fpu_start`=1 from N+1.
- `fpu_done` sampled high at edge M → `fpu_start`=0, done=1, result valid from M+1. Status read at edge M returns busy=1, done=0.
- Minimum transaction: 3 cycles plus core latency. Back-to-back commands are accepted only after RELEASE returns to IDLE.
- Status read and completion on the same edge: the read returns the pre-update status.
- `arst` mid-transaction: FSM → IDLE, `fpu_start`=0, all registers cleared next edge. The core must also be reset by the same `arst`.
- A spurious `fpu_done` in IDLE is ignored.

## Configuration
- `FPU_IRQ_EN` defined:
  - `irq` sets on the REQ→RELEASE transition when the enable bit is 1.
  - `irq` clears on 0xF write with bit1=1, on a new command, or on reset. Clear wins over a simultaneous set.
  - 0xF reads {7'b0, enable}.
- `FPU_IRQ_EN` undefined:
  - `irq` is tied 0.
  - 0xF writes are ignored and 0xF reads return 0.

## Test plan
- Reset: assert `arst` 2 cycles → all outputs 0, status reads 0x00.
- Add, with a core model of 5-cycle latency:
  - Stimulus: A=0x3F800000, B=0x40000000, op=0x0, command write.
  - Required: `fpu_start` high the following cycle; done seen → result bytes 0xB..0xE read 00,00,40,40; status 0x02.
- Busy lockout: write A byte 0 = 0xFF during REQ → `fpu_a` unchanged. A second command write during REQ → no second start.
- Illegal op: op=0xF, command write → status 0x04, `fpu_start` stays 0. Then op=0x2 and a command → err cleared, start issued.
- IRQ (`FPU_IRQ_EN`): enable=1, run op_mul → `irq`=1 one cycle after done is sampled. Write 0xF=0x02 → `irq`=0 next cycle. Build without the macro → `irq` is never 1.
- Reset mid-REQ: `arst` while `fpu_start`=1 → `fpu_start`=0 next cycle, status 0x00, result 0.
